// File: rtl/runcode_parse.sv
// Bit-serial run-code word parser: a prefix of '1' run segments,
// then an optional tail made of a '0' plus rem_len remainder bits.
module runcode_parse #(
  parameter int REM_MAX = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  rem_len,
  input  logic [5:0]  max_ones,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [5:0]  codes_len1,
  output logic [10:0] codes_2,
  output logic [3:0]  codes_len2,
  output logic        en_out,
  output logic        len_err,
  output logic        busy
);

  localparam int TW = REM_MAX + 1;
  localparam logic [3:0] RMAX = 4'(REM_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ONES,
    S_REM,
    S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    rem_q;
  logic [5:0]    lim;
  logic          err;
  logic [5:0]    cnt;
  logic [TW-1:0] tail;
  logic [3:0]    len2;
  logic [3:0]    remaining;

  logic          xfer;
  logic [5:0]    cnt_nx;
  logic [TW-1:0] tail_nx;
  logic [3:0]    len2_nx;

  assign bit_ready = (state == S_ONES) || (state == S_REM);
  assign busy      = (state != S_IDLE);

  always_comb begin
    xfer    = bit_valid & bit_ready;
    cnt_nx  = cnt + 6'd1;
    tail_nx = {tail[TW-2:0], bit_in};
    len2_nx = len2 + 4'd1;
  end

  // Results are registered on the final transfer so that they are
  // already stable while DONE holds en_out high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      rem_q      <= '0;
      lim        <= '0;
      err        <= 1'b0;
      cnt        <= '0;
      tail       <= '0;
      len2       <= '0;
      remaining  <= '0;
      codes_len1 <= '0;
      codes_2    <= '0;
      codes_len2 <= '0;
      en_out     <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      en_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (rem_len > RMAX) begin
              rem_q <= RMAX;
              err   <= 1'b1;
            end else begin
              rem_q <= rem_len;
              err   <= 1'b0;
            end
            lim       <= (max_ones == 6'd0) ? 6'd63 : max_ones;
            cnt       <= '0;
            tail      <= '0;
            len2      <= '0;
            remaining <= '0;
            state     <= S_ONES;
          end
        end
        S_ONES: begin
          if (xfer) begin
            if (bit_in) begin
              cnt <= cnt_nx;
              if (cnt_nx == lim) begin
                codes_len1 <= cnt_nx;
                codes_2    <= tail;
                codes_len2 <= 4'd0;
                len_err    <= err;
                en_out     <= 1'b1;
                state      <= S_DONE;
              end
            end else begin
              tail <= tail_nx;
              len2 <= 4'd1;
              if (rem_q == 4'd0) begin
                codes_len1 <= cnt;
                codes_2    <= tail_nx;
                codes_len2 <= 4'd1;
                len_err    <= err;
                en_out     <= 1'b1;
                state      <= S_DONE;
              end else begin
                remaining <= rem_q;
                state     <= S_REM;
              end
            end
          end
        end
        S_REM: begin
          if (xfer) begin
            tail      <= tail_nx;
            len2      <= len2_nx;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              codes_len1 <= cnt;
              codes_2    <= tail_nx;
              codes_len2 <= len2_nx;
              len_err    <= err;
              en_out     <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/runcode_parse.md
Name: runcode_parse

Overview:
- Bit-serial decoder for run-mode code words: the inverse of the run-code builder on the encoder side.
- Consumes the compressed bitstream one bit per cycle, MSB-first.
- Splits each code word into a prefix of '1' bits (run segments) and an optional tail: a terminating '0' plus rem_len remainder bits.
- Sits between the bitstream unpacker and the run-length reconstruction stage of the decoder.

Parameters:
REM_MAX, 10, maximum remainder bits after the terminating zero (tail field is REM_MAX+1 bits wide).

Ports:
clk         input   1    system clock
reset       input   1    synchronous active-low reset
start       input   1    begin parsing one code word; sampled only in IDLE
rem_len     input   4    remainder bits following the terminating '0'; latched on start
max_ones    input   6    prefix length that ends the word without a tail (end of line); 0 means 63; latched on start
bit_in      input   1    stream bit
bit_valid   input   1    bit_in valid
bit_ready   output  1    parser accepts a bit this cycle
codes_len1  output  6    number of '1' prefix bits decoded
codes_2     output  11   tail value, right-aligned; first tail bit is the MSB of a codes_len2-bit field
codes_len2  output  4    tail length including the terminating '0' (0 = no tail)
en_out      output  1    one-cycle strobe: codes_len1/codes_2/codes_len2 valid
len_err     output  1    rem_len > REM_MAX was clamped; valid with en_out
busy        output  1    state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low. reset=0 at a clock edge forces IDLE and clears all outputs and internal registers to 0. This applies mid-word too; any partially parsed word is discarded.
- A bit transfers on a cycle where bit_valid=1 and bit_ready=1. bit_valid while bit_ready=0 has no effect; the bit is not consumed.
- States: IDLE, ONES, REM, DONE.
- IDLE:
  - bit_ready=0.
  - On start=1: latch rem_len (values >REM_MAX clamp to REM_MAX and set an internal err flag); latch lim = (max_ones==0)?63:max_ones.
  - Clear the ones counter, tail shift register, tail length and remaining counter; go to ONES.
- ONES:
  - bit_ready=1.
  - Transfer of '1': cnt<=cnt+1. If cnt+1==lim, go to DONE with codes_len2=0.
  - Transfer of '0': shift 0 into the tail, len2<=1. If the latched rem_len==0, go to DONE; else go to REM with remaining=rem_len.
- REM:
  - bit_ready=1.
  - Each transfer: tail<={tail[9:0],bit_in}, len2<=len2+1, remaining<=remaining-1.
  - When remaining==1 on a transfer, go to DONE.
- DONE:
  - bit_ready=0.
  - Register codes_len1=cnt, codes_2=tail, codes_len2=len2, len_err=err; en_out=1 for exactly this cycle; go to IDLE.
- Latency: en_out is asserted one cycle after the final bit transfer. Back-to-back words therefore need start in the cycle after en_out (IDLE); there is a minimum 2-cycle gap between the last bit of one word and the first bit of the next.
- Output hold: codes_len1/codes_2/codes_len2/len_err hold their last values until the next DONE. en_out is 0 outside DONE.
- start while busy is ignored. start and reset=0 together: reset wins.
- Consistency: the encoder's field {codes_len1 ones, codes_2 of codes_len2 bits} re-encodes exactly to the consumed bits. codes_2 < 2^(codes_len2-1) whenever codes_len2>0. codes_len1+codes_len2 ≤ 63+11.
- bit_valid gaps in ONES/REM stall the FSM indefinitely with no timeout; counters hold.

Test Plan:
- start, rem_len=3, max_ones=20; bits 1,1,1,0,1,0,1 → en_out one cycle after the 7th bit with codes_len1=3, codes_len2=4, codes_2=0x5.
- rem_len=0, max_ones=10; bits 1,1,0 → codes_len1=2, codes_len2=1, codes_2=0; en_out 1 cycle after the '0'.
- max_ones=4, rem_len=5; bits 1,1,1,1 → DONE after the 4th '1', codes_len1=4, codes_len2=0; bit_ready=0 afterwards so a following '0' is not consumed.
- max_ones=0, 63 consecutive '1' → codes_len1=63, codes_len2=0. rem_len=13 word with bits 0 then 10 ones → codes_2=0x3FF, codes_len2=11, len_err=1.
- bit_valid toggling randomly during a rem_len=2 word (bits 1,0,1,1) → same result as the contiguous case (codes_len1=1, codes_len2=3, codes_2=3); start pulsed while busy → ignored.
- reset=0 asserted in REM after 2 tail bits → next cycle IDLE, all outputs 0, no en_out. A fresh word then decodes correctly.
